// File: rtl/decode_issue_stage.sv
// MIPS decode/issue stage: decodes one instruction per cycle, forwards operands from
// EX/MEM and MEM/WB, stalls on unresolved hazards and registers the ID/EX bundle.
module decode_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic        exmem_wr_en,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_data,
  input  logic        exmem_is_load,
  input  logic        memwb_wr_en,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic        ex_valid,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_func,
  output logic [4:0]  ex_sa,
  output logic [31:0] ex_first,
  output logic [31:0] ex_second,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dest,
  output logic        ex_wr_en,
  output logic        ex_is_load,
  output logic        ex_is_store
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;

  typedef enum logic [1:0] {SEC_ZERO, SEC_RT, SEC_SEXT, SEC_ZEXT} sec_sel_t;

  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [15:0] imm;

  assign opcode  = in_instr[31:26];
  assign rs_addr = in_instr[25:21];
  assign rt_addr = in_instr[20:16];
  assign rd      = in_instr[15:11];
  assign sa      = in_instr[10:6];
  assign func    = in_instr[5:0];
  assign imm     = in_instr[15:0];

  logic     uses_rs;
  logic     uses_rt;
  logic     writes;
  logic     is_load;
  logic     is_store;
  logic [4:0] dest;
  sec_sel_t sec_sel;

  always_comb begin
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    writes   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    dest     = 5'd0;
    sec_sel  = SEC_ZERO;
    unique case (opcode)
      OP_RTYPE: begin
        // Immediate shifts take their amount from sa, so the rs field is ignored.
        uses_rs = !(func == FN_SLL || func == FN_SRL || func == FN_SRA);
        uses_rt = 1'b1;
        writes  = 1'b1;
        dest    = rd;
        sec_sel = SEC_RT;
      end
      OP_ADDI, OP_ADDIU: begin
        uses_rs = 1'b1;
        writes  = 1'b1;
        dest    = rt_addr;
        sec_sel = SEC_SEXT;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        uses_rs = 1'b1;
        writes  = 1'b1;
        dest    = rt_addr;
        sec_sel = SEC_ZEXT;
      end
      OP_LW: begin
        uses_rs = 1'b1;
        writes  = 1'b1;
        is_load = 1'b1;
        dest    = rt_addr;
        sec_sel = SEC_SEXT;
      end
      OP_SW: begin
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
        is_store = 1'b1;
        sec_sel  = SEC_SEXT;
      end
      OP_BEQ, OP_BNE: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        sec_sel = SEC_RT;
      end
      OP_J, OP_JAL: begin
        sec_sel = SEC_ZERO;
      end
      default: begin
        sec_sel = SEC_ZERO;
      end
    endcase
  end

  // Index 0 is the rs path, index 1 the rt path.
  logic [4:0]  src_addr [2];
  logic [31:0] src_rf   [2];
  logic [31:0] src_value[2];
  logic [1:0]  src_used;
  logic [1:0]  hazard;

  assign src_addr[0] = rs_addr;
  assign src_addr[1] = rt_addr;
  assign src_rf[0]   = rs_data;
  assign src_rf[1]   = rt_data;
  assign src_used    = {uses_rt, uses_rs};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic is_zero;
      logic exmem_hit;
      logic memwb_hit;
      assign is_zero   = (src_addr[gi] == 5'd0);
      assign exmem_hit = exmem_wr_en && (exmem_rd == src_addr[gi]);
      assign memwb_hit = memwb_wr_en && (memwb_rd == src_addr[gi]);

      // Loads in EX/MEM have no data yet; they are handled by stalling instead.
      assign src_value[gi] = is_zero                     ? 32'd0      :
                             (exmem_hit && !exmem_is_load) ? exmem_data :
                             memwb_hit                   ? memwb_data : src_rf[gi];

      assign hazard[gi] = src_used[gi] && !is_zero &&
                          ((ex_valid && ex_wr_en && (ex_dest == src_addr[gi])) ||
                           (exmem_hit && exmem_is_load));
    end
  endgenerate

  logic        stall;
  logic        issue;
  logic [31:0] second_next;

  assign stall    = in_valid && (|hazard);
  assign issue    = in_valid && !stall && !flush;
  assign in_ready = !reset && (!stall || flush);

  always_comb begin
    second_next = 32'd0;
    unique case (sec_sel)
      SEC_RT:   second_next = src_value[1];
      SEC_SEXT: second_next = {{16{imm[15]}}, imm};
      SEC_ZEXT: second_next = {16'd0, imm};
      default:  second_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !issue) begin
      ex_valid      <= 1'b0;
      ex_opcode     <= 6'd0;
      ex_func       <= 6'd0;
      ex_sa         <= 5'd0;
      ex_first      <= 32'd0;
      ex_second     <= 32'd0;
      ex_store_data <= 32'd0;
      ex_dest       <= 5'd0;
      ex_wr_en      <= 1'b0;
      ex_is_load    <= 1'b0;
      ex_is_store   <= 1'b0;
    end else begin
      ex_valid      <= 1'b1;
      ex_opcode     <= opcode;
      ex_func       <= func;
      ex_sa         <= sa;
      ex_first      <= src_value[0];
      ex_second     <= second_next;
      ex_store_data <= is_store ? src_value[1] : 32'd0;
      ex_dest       <= dest;
      ex_wr_en      <= writes && (dest != 5'd0);
      ex_is_load    <= is_load;
      ex_is_store   <= is_store;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed self-checking bench for decode_issue_stage: one task per scenario,
// expected values hand-computed from the instruction encodings.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        flush;
  logic        exmem_wr_en;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_data;
  logic        exmem_is_load;
  logic        memwb_wr_en;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        ex_valid;
  logic [5:0]  ex_opcode, ex_func;
  logic [4:0]  ex_sa;
  logic [31:0] ex_first, ex_second, ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_wr_en, ex_is_load, ex_is_store;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .exmem_is_load(exmem_is_load), .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_func(ex_func), .ex_sa(ex_sa), .ex_first(ex_first), .ex_second(ex_second),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store)
  );

  // Encodings used throughout
  localparam logic [31:0] I_ADDI  = 32'h2022FFFC; // addi $2,$1,-4
  localparam logic [31:0] I_ORI   = 32'h34038001; // ori  $3,$0,0x8001
  localparam logic [31:0] I_SW    = 32'hAC270008; // sw   $7,8($1)
  localparam logic [31:0] I_BAD   = 32'hFC000000; // opcode 0x3F
  localparam logic [31:0] I_ADD   = 32'h00A62020; // add  $4,$5,$6
  localparam logic [31:0] I_ADD0  = 32'h00062020; // add  $4,$0,$6
  localparam logic [31:0] I_LW    = 32'h8C280000; // lw   $8,0($1)
  localparam logic [31:0] I_SUB   = 32'h01084822; // sub  $9,$8,$8
  localparam logic [31:0] I_ADD11 = 32'h00425820; // add  $11,$2,$2
  localparam logic [31:0] I_SLL   = 32'h016350C0; // sll  $10,$3,3 with rs field = 11
  localparam logic [31:0] I_ADDF  = 32'h014A5820; // add  $11,$10,$10
  localparam logic [31:0] I_ADD12 = 32'h00636020; // add  $12,$3,$3

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_valid = 0; in_instr = 0; flush = 0;
    rs_data = 0; rt_data = 0;
    exmem_wr_en = 0; exmem_rd = 0; exmem_data = 0; exmem_is_load = 0;
    memwb_wr_en = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic test_reset();
    quiet();
    reset = 1;
    in_valid = 1; in_instr = I_ADDI; rs_data = 32'd10;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready);
    end
    checks++;
    if ({ex_valid, ex_opcode, ex_func, ex_sa, ex_first, ex_second, ex_store_data,
         ex_dest, ex_wr_en, ex_is_load, ex_is_store} !== '0) begin
      failures++; $display("FAIL reset_outputs valid=%0b first=%h dest=%0d exp all zero",
                           ex_valid, ex_first, ex_dest);
    end
    reset = 0;
    quiet();
    tick();
    $display("reset: done");
  endtask

  task automatic test_back_to_back();
    quiet();
    in_valid = 1; in_instr = I_ADDI; rs_data = 32'd10; rt_data = 32'h2222;
    #1;
    checks++;
    if ({rs_addr, rt_addr, in_ready} !== {5'd1, 5'd2, 1'b1}) begin
      failures++; $display("FAIL addi_addr rs=%0d rt=%0d rdy=%0b exp 1 2 1", rs_addr, rt_addr, in_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_opcode, ex_first, ex_second, ex_dest, ex_wr_en, ex_is_load, ex_is_store} !==
        {1'b1, 6'h08, 32'd10, 32'hFFFFFFFC, 5'd2, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL addi_issue first=%h second=%h dest=%0d wr=%0b exp 0000000a fffffffc 2 1",
                           ex_first, ex_second, ex_dest, ex_wr_en);
    end
    $display("issue addi: first=%h second=%h", ex_first, ex_second);
    in_instr = I_ORI; rs_data = 32'h1111;
    tick();
    checks++;
    if ({ex_valid, ex_first, ex_second, ex_dest, ex_wr_en} !== {1'b1, 32'd0, 32'h00008001, 5'd3, 1'b1}) begin
      failures++; $display("FAIL ori_issue first=%h second=%h dest=%0d exp 00000000 00008001 3",
                           ex_first, ex_second, ex_dest);
    end
    $display("issue ori: first=%h second=%h", ex_first, ex_second);
    in_instr = I_SW; rs_data = 32'h100; rt_data = 32'hCAFE;
    tick();
    checks++;
    if ({ex_valid, ex_first, ex_second, ex_store_data, ex_dest, ex_wr_en, ex_is_load, ex_is_store} !==
        {1'b1, 32'h100, 32'd8, 32'hCAFE, 5'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL sw_issue first=%h second=%h store=%h dest=%0d wr=%0b st=%0b",
                           ex_first, ex_second, ex_store_data, ex_dest, ex_wr_en, ex_is_store);
    end
    $display("issue sw: store=%h", ex_store_data);
    in_instr = I_BAD;
    tick();
    checks++;
    if ({ex_valid, ex_opcode, ex_wr_en, ex_is_load, ex_is_store} !== {1'b1, 6'h3F, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL bad_opcode valid=%0b op=%h wr=%0b ld=%0b st=%0b",
                           ex_valid, ex_opcode, ex_wr_en, ex_is_load, ex_is_store);
    end
    $display("issue unknown opcode: op=%h", ex_opcode);
  endtask

  task automatic test_forwarding();
    quiet();
    in_valid = 1; in_instr = I_ADD; rs_data = 32'd100; rt_data = 32'd200;
    exmem_wr_en = 1; exmem_rd = 5; exmem_data = 32'd7;
    memwb_wr_en = 1; memwb_rd = 5; memwb_data = 32'd9;
    tick();
    checks++;
    if ({ex_first, ex_second, ex_dest} !== {32'd7, 32'd200, 5'd4}) begin
      failures++; $display("FAIL fwd_exmem_wins first=%0d second=%0d dest=%0d exp 7 200 4",
                           ex_first, ex_second, ex_dest);
    end
    $display("forward exmem over memwb: first=%0d", ex_first);
    memwb_rd = 6; memwb_data = 32'd3;
    tick();
    checks++;
    if ({ex_first, ex_second} !== {32'd7, 32'd3}) begin
      failures++; $display("FAIL fwd_both first=%0d second=%0d exp 7 3", ex_first, ex_second);
    end
    $display("forward rs/exmem rt/memwb: first=%0d second=%0d", ex_first, ex_second);
    exmem_wr_en = 0; in_instr = I_ADD0; rs_data = 32'd99; rt_data = 32'd5;
    memwb_rd = 0; memwb_data = 32'd55;
    tick();
    checks++;
    if ({ex_first, ex_second} !== {32'd0, 32'd5}) begin
      failures++; $display("FAIL fwd_reg0 first=%0d second=%0d exp 0 5", ex_first, ex_second);
    end
    $display("reg0 never forwarded: first=%0d", ex_first);
  endtask

  task automatic test_load_use();
    quiet();
    in_valid = 1; in_instr = I_LW; rs_data = 32'h40;
    tick();
    checks++;
    if ({ex_valid, ex_is_load, ex_dest, ex_wr_en} !== {1'b1, 1'b1, 5'd8, 1'b1}) begin
      failures++; $display("FAIL lw_issue valid=%0b ld=%0b dest=%0d wr=%0b exp 1 1 8 1",
                           ex_valid, ex_is_load, ex_dest, ex_wr_en);
    end
    in_instr = I_SUB; rs_data = 32'h5555; rt_data = 32'h5555;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL loaduse_c2_ready got=%0b exp=0", in_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_wr_en, ex_is_load, ex_is_store} !== 4'b0) begin
      failures++; $display("FAIL loaduse_c2_bubble valid=%0b wr=%0b exp 0 0", ex_valid, ex_wr_en);
    end
    exmem_wr_en = 1; exmem_rd = 8; exmem_is_load = 1; exmem_data = 32'hDEAD;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL loaduse_c3_ready got=%0b exp=0", in_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_wr_en} !== 2'b0) begin
      failures++; $display("FAIL loaduse_c3_bubble valid=%0b wr=%0b exp 0 0", ex_valid, ex_wr_en);
    end
    exmem_wr_en = 0; exmem_is_load = 0;
    memwb_wr_en = 1; memwb_rd = 8; memwb_data = 32'h1234;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL loaduse_c4_ready got=%0b exp=1", in_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_first, ex_second, ex_dest, ex_func} !== {1'b1, 32'h1234, 32'h1234, 5'd9, 6'h22}) begin
      failures++; $display("FAIL loaduse_c4_issue first=%h second=%h dest=%0d exp 00001234 00001234 9",
                           ex_first, ex_second, ex_dest);
    end
    $display("load-use: sub issued after 2 bubbles, first=%h", ex_first);
  endtask

  task automatic test_stall_one_bubble();
    quiet();
    in_valid = 1; in_instr = I_ADDI; rs_data = 32'd1;
    tick();
    in_instr = I_ADD11; rs_data = 32'h0BAD; rt_data = 32'h0BAD;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL stallA_ready got=%0b exp=0", in_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_wr_en} !== 2'b0) begin
      failures++; $display("FAIL stallA_bubble valid=%0b wr=%0b exp 0 0", ex_valid, ex_wr_en);
    end
    exmem_wr_en = 1; exmem_rd = 2; exmem_data = 32'h77;
    tick();
    checks++;
    if ({ex_valid, ex_first, ex_second, ex_dest} !== {1'b1, 32'h77, 32'h77, 5'd11}) begin
      failures++; $display("FAIL stallA_issue first=%h second=%h dest=%0d exp 00000077 00000077 11",
                           ex_first, ex_second, ex_dest);
    end
    $display("stall A: add issued after 1 bubble, first=%h", ex_first);
    exmem_wr_en = 0;
    in_instr = I_SLL; rs_data = 32'h0BAD; rt_data = 32'h0F0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL sll_no_stall_ready got=%0b exp=1", in_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_dest, ex_sa, ex_second, ex_wr_en} !== {1'b1, 5'd10, 5'd3, 32'h0F0, 1'b1}) begin
      failures++; $display("FAIL sll_issue valid=%0b dest=%0d sa=%0d second=%h exp 1 10 3 000000f0",
                           ex_valid, ex_dest, ex_sa, ex_second);
    end
    $display("sll with matching rs field: no stall");
  endtask

  task automatic test_flush();
    quiet();
    in_valid = 1; in_instr = I_ADDF;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL flush_pre_ready got=%0b exp=0", in_ready);
    end
    flush = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_ready got=%0b exp=1", in_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_wr_en, ex_is_load, ex_is_store} !== 4'b0) begin
      failures++; $display("FAIL flush_bubble valid=%0b wr=%0b exp 0 0", ex_valid, ex_wr_en);
    end
    quiet();
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin
      failures++; $display("FAIL flush_dropped valid=%0b exp=0", ex_valid);
    end
    $display("flush during stall: instruction dropped");
  endtask

  task automatic test_reset_mid_stream();
    quiet();
    in_valid = 1;
    in_instr = I_ADDI; rs_data = 32'd10; tick();
    in_instr = I_SW; rs_data = 32'h100; rt_data = 32'h5; tick();
    in_instr = I_ORI; tick();
    in_instr = I_ADD12; rs_data = 32'h3C; rt_data = 32'h4;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL midreset_stall_ready got=%0b exp=0", in_ready);
    end
    reset = 1; flush = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL midreset_ready got=%0b exp=0", in_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_opcode, ex_func, ex_sa, ex_first, ex_second, ex_store_data,
         ex_dest, ex_wr_en, ex_is_load, ex_is_store} !== '0) begin
      failures++; $display("FAIL midreset_outputs valid=%0b first=%h dest=%0d exp all zero",
                           ex_valid, ex_first, ex_dest);
    end
    reset = 0; flush = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL postreset_ready got=%0b exp=1", in_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_first, ex_second, ex_dest, ex_wr_en} !== {1'b1, 32'h3C, 32'h4, 5'd12, 1'b1}) begin
      failures++; $display("FAIL postreset_issue first=%h second=%h dest=%0d exp 0000003c 00000004 12",
                           ex_first, ex_second, ex_dest);
    end
    $display("reset mid-stream: add $12 issued after reset, first=%h", ex_first);
  endtask

  initial begin
    reset = 1;
    quiet();
    test_reset();
    test_back_to_back();
    test_forwarding();
    test_load_use();
    test_stall_one_bubble();
    test_flush();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
